// File: rtl/mem_arb_pkg.sv
// Shared state encoding and owner codes for the memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_D  = 2'd2
   } arb_state_t;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU-side request/completion signals and memory-side handshake of the shared port.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_valid;
   logic [DATA_W-1:0] if_rdata;
   logic              if_err;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_valid;
   logic [DATA_W-1:0] d_rdata;
   logic              d_err;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;
   logic              owner;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
      output if_valid, if_rdata, if_err, d_valid, d_rdata, d_err,
      output mem_req, mem_we, mem_addr, mem_wdata, busy, owner
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
      input  if_valid, if_rdata, if_err, d_valid, d_rdata, d_err,
      input  mem_req, mem_we, mem_addr, mem_wdata, busy, owner
   );
endinterface

// File: rtl/mem_port_arbiter_timeout.sv
// Busy-cycle watchdog: counts cycles without acknowledgement and flags the last one.
module arb_timeout #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam int             CW   = $clog2(TIMEOUT);
   localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_r;

   // Cycle counter, held at its final value until cleared by the next access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (clr) begin
         cnt_r <= '0;
      end else if (en && (cnt_r != LAST)) begin
         cnt_r <= cnt_r + CW'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expire = en & ~clr & (cnt_r == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data requesters; data wins ties
// for a bounded burst, and a watchdog aborts accesses the memory never acknowledges.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MAX_D_BURST = 4,
   parameter int TIMEOUT     = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_port_arbiter_if.slave bus
);
   localparam logic [1:0]     S_IDLE    = IDLE;
   localparam logic [1:0]     S_BUSY_IF = BUSY_IF;
   localparam logic [1:0]     S_BUSY_D  = BUSY_D;
   localparam int             BW        = $clog2(MAX_D_BURST + 1);
   localparam logic [BW-1:0]  BURST_MAX = BW'(MAX_D_BURST);

   logic [1:0]        state_r;
   logic [BW-1:0]     burst_r;
   logic              first_r;
   logic              mem_req_r;
   logic              mem_we_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;
   logic              owner_r;
   logic              if_valid_r;
   logic              if_err_r;
   logic [DATA_W-1:0] if_rdata_r;
   logic              d_valid_r;
   logic              d_err_r;
   logic [DATA_W-1:0] d_rdata_r;

   logic              cand_if_s;
   logic              cand_d_s;
   logic              grant_if_s;
   logic              grant_d_s;
   logic [BW-1:0]     burst_inc_s;
   logic              tmo_en_s;
   logic              expire_s;

   // Grant decision; a requester completing this cycle is masked so it is not re-granted.
   always_comb begin
      cand_if_s   = bus.if_req & ~if_valid_r;
      cand_d_s    = bus.d_req & ~d_valid_r;
      grant_if_s  = 1'b0;
      grant_d_s   = 1'b0;
      burst_inc_s = burst_r;
      if (burst_r < BURST_MAX) begin
         burst_inc_s = burst_r + BW'(1);
      end else begin
         burst_inc_s = burst_r;
      end
      if (state_r == S_IDLE) begin
         if (cand_d_s && (!cand_if_s || (burst_r < BURST_MAX))) begin
            grant_d_s = 1'b1;
         end else if (cand_if_s) begin
            grant_if_s = 1'b1;
         end else begin
            grant_if_s = 1'b0;
            grant_d_s  = 1'b0;
         end
      end else begin
         grant_if_s = 1'b0;
         grant_d_s  = 1'b0;
      end
   end

   assign tmo_en_s = (state_r != S_IDLE) & ~bus.mem_ready;

   // The first busy cycle clears the watchdog, giving TIMEOUT+1 busy cycles in total.
   arb_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (first_r),
      .en     (tmo_en_s),
      .expire (expire_s)
   );

   // State, latched memory access, completion outputs and fairness counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         burst_r     <= '0;
         first_r     <= 1'b0;
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
         owner_r     <= OWN_IF;
         if_valid_r  <= 1'b0;
         if_err_r    <= 1'b0;
         if_rdata_r  <= '0;
         d_valid_r   <= 1'b0;
         d_err_r     <= 1'b0;
         d_rdata_r   <= '0;
      end else begin
         if_valid_r <= 1'b0;
         d_valid_r  <= 1'b0;
         first_r    <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (grant_d_s) begin
                  state_r     <= S_BUSY_D;
                  mem_req_r   <= 1'b1;
                  mem_we_r    <= bus.d_we;
                  mem_addr_r  <= bus.d_addr;
                  mem_wdata_r <= bus.d_wdata;
                  owner_r     <= OWN_D;
                  first_r     <= 1'b1;
                  burst_r     <= cand_if_s ? burst_inc_s : '0;
               end else if (grant_if_s) begin
                  state_r     <= S_BUSY_IF;
                  mem_req_r   <= 1'b1;
                  mem_we_r    <= 1'b0;
                  mem_addr_r  <= bus.if_addr;
                  mem_wdata_r <= '0;
                  owner_r     <= OWN_IF;
                  first_r     <= 1'b1;
                  burst_r     <= '0;
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_BUSY_IF: begin
               if (bus.mem_ready) begin
                  state_r    <= S_IDLE;
                  mem_req_r  <= 1'b0;
                  if_valid_r <= 1'b1;
                  if_err_r   <= 1'b0;
                  if_rdata_r <= bus.mem_rdata;
               end else if (expire_s) begin
                  state_r    <= S_IDLE;
                  mem_req_r  <= 1'b0;
                  if_valid_r <= 1'b1;
                  if_err_r   <= 1'b1;
                  if_rdata_r <= '0;
               end else begin
                  state_r <= S_BUSY_IF;
               end
            end
            S_BUSY_D: begin
               if (bus.mem_ready) begin
                  state_r   <= S_IDLE;
                  mem_req_r <= 1'b0;
                  d_valid_r <= 1'b1;
                  d_err_r   <= 1'b0;
                  d_rdata_r <= mem_we_r ? '0 : bus.mem_rdata;
               end else if (expire_s) begin
                  state_r   <= S_IDLE;
                  mem_req_r <= 1'b0;
                  d_valid_r <= 1'b1;
                  d_err_r   <= 1'b1;
                  d_rdata_r <= '0;
               end else begin
                  state_r <= S_BUSY_D;
               end
            end
            default: begin
               state_r   <= S_IDLE;
               mem_req_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_req   = mem_req_r;
   assign bus.busy      = mem_req_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign bus.owner     = owner_r;
   assign bus.if_valid  = if_valid_r;
   assign bus.if_err    = if_err_r;
   assign bus.if_rdata  = if_rdata_r;
   assign bus.d_valid   = d_valid_r;
   assign bus.d_err     = d_err_r;
   assign bus.d_rdata   = d_rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_port_arbiter;
   localparam int TMO  = 8;
   localparam int MAXB = 4;

   logic clk;
   logic rst_n;
   logic chk_en;
   int   n_checks;
   int   n_errors;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .MAX_D_BURST (MAXB),
      .TIMEOUT     (TMO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: one outstanding access (owner, latched fields, cycles used) plus the completion outputs.
   bit          m_busy;
   bit          m_own;
   bit          m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   int          m_age;
   int          m_burst;
   bit          e_if_valid;
   bit          e_if_err;
   logic [31:0] e_if_rdata;
   bit          e_d_valid;
   bit          e_d_err;
   logic [31:0] e_d_rdata;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_own = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_age = 0; m_burst = 0;
      e_if_valid = 0; e_if_err = 0; e_if_rdata = '0;
      e_d_valid = 0; e_d_err = 0; e_d_rdata = '0;
   endtask

   task automatic model_step();
      bit cif, cd, nvi, nvd, take_d;
      cif = bus.if_req && !e_if_valid;
      cd  = bus.d_req && !e_d_valid;
      nvi = 0;
      nvd = 0;
      if (m_busy) begin
         if (bus.mem_ready || m_age == TMO) begin
            if (m_own) begin
               nvd       = 1;
               e_d_err   = !bus.mem_ready;
               e_d_rdata = (bus.mem_ready && !m_we) ? bus.mem_rdata : 32'h0;
            end else begin
               nvi        = 1;
               e_if_err   = !bus.mem_ready;
               e_if_rdata = bus.mem_ready ? bus.mem_rdata : 32'h0;
            end
            m_busy = 0;
         end else begin
            m_age++;
         end
      end else if (cd || cif) begin
         take_d = cd && (!cif || m_burst < MAXB);
         m_busy = 1;
         m_age  = 0;
         m_own  = take_d;
         if (take_d) begin
            m_we    = bus.d_we;
            m_addr  = bus.d_addr;
            m_wdata = bus.d_wdata;
            m_burst = cif ? ((m_burst + 1 > MAXB) ? MAXB : m_burst + 1) : 0;
         end else begin
            m_we    = 0;
            m_addr  = bus.if_addr;
            m_burst = 0;
         end
      end
      e_if_valid = nvi;
      e_d_valid  = nvd;
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst_n) model_step();
      else model_reset();
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " mem_req"},   32'(bus.mem_req),   32'h0);
      chk({tag, " mem_we"},    32'(bus.mem_we),    32'h0);
      chk({tag, " mem_addr"},  bus.mem_addr,       32'h0);
      chk({tag, " mem_wdata"}, bus.mem_wdata,      32'h0);
      chk({tag, " if_valid"},  32'(bus.if_valid),  32'h0);
      chk({tag, " d_valid"},   32'(bus.d_valid),   32'h0);
      chk({tag, " if_rdata"},  bus.if_rdata,       32'h0);
      chk({tag, " d_rdata"},   bus.d_rdata,        32'h0);
      chk({tag, " if_err"},    32'(bus.if_err),    32'h0);
      chk({tag, " d_err"},     32'(bus.d_err),     32'h0);
      chk({tag, " busy"},      32'(bus.busy),      32'h0);
      chk({tag, " owner"},     32'(bus.owner),     32'h0);
   endtask

   // Per-cycle comparison of every meaningful DUT output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("mem_req",  32'(bus.mem_req),  32'(m_busy));
         chk("busy",     32'(bus.busy),     32'(m_busy));
         chk("owner",    32'(bus.owner),    32'(m_own));
         chk("if_valid", 32'(bus.if_valid), 32'(e_if_valid));
         chk("d_valid",  32'(bus.d_valid),  32'(e_d_valid));
         chk("if_rdata", bus.if_rdata,      e_if_rdata);
         chk("if_err",   32'(bus.if_err),   32'(e_if_err));
         chk("d_rdata",  bus.d_rdata,       e_d_rdata);
         chk("d_err",    32'(bus.d_err),    32'(e_d_err));
         if (m_busy) begin
            chk("mem_we",   32'(bus.mem_we), 32'(m_we));
            chk("mem_addr", bus.mem_addr,    m_addr);
            if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
         end
      end
   end

   initial begin
      bit if_pend, d_pend;
      int stall;
      n_checks = 0;
      n_errors = 0;
      chk_en   = 1'b0;
      rst_n    = 1'b0;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      bus.mem_ready = 1'b0; bus.mem_rdata = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Lone fetch.
      bus.if_req = 1'b1; bus.if_addr = 32'h0000_0010;
      cycle();
      chk("fetch mem_req",  32'(bus.mem_req), 32'h1);
      chk("fetch mem_addr", bus.mem_addr,     32'h0000_0010);
      chk("fetch mem_we",   32'(bus.mem_we),  32'h0);
      cycle();
      cycle();
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0050_0093;
      cycle();
      chk("fetch if_valid", 32'(bus.if_valid), 32'h1);
      chk("fetch if_rdata", bus.if_rdata,      32'h0050_0093);
      chk("fetch if_err",   32'(bus.if_err),   32'h0);
      bus.if_req = 1'b0; bus.mem_ready = 1'b0;
      repeat (2) cycle();

      // Simultaneous store and fetch: data first, then fetch after one idle cycle.
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_0100; bus.d_wdata = 32'hDEAD_BEEF;
      bus.if_req = 1'b1; bus.if_addr = 32'h0000_0020;
      cycle();
      chk("sim mem_we",    32'(bus.mem_we), 32'h1);
      chk("sim mem_wdata", bus.mem_wdata,   32'hDEAD_BEEF);
      chk("sim mem_addr",  bus.mem_addr,    32'h0000_0100);
      chk("sim owner d",   32'(bus.owner),  32'h1);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
      cycle();
      chk("sim d_valid",   32'(bus.d_valid), 32'h1);
      chk("sim d_rdata",   bus.d_rdata,      32'h0);
      chk("sim gap",       32'(bus.mem_req), 32'h0);
      bus.d_req = 1'b0; bus.mem_ready = 1'b0;
      cycle();
      chk("sim if grant",  32'(bus.mem_req), 32'h1);
      chk("sim owner if",  32'(bus.owner),   32'h0);
      chk("sim if addr",   bus.mem_addr,     32'h0000_0020);
      bus.mem_ready = 1'b1;
      cycle();
      chk("sim if_valid",  32'(bus.if_valid), 32'h1);
      bus.if_req = 1'b0; bus.mem_ready = 1'b0;
      repeat (2) cycle();

      // Timeout on a load, then a late acknowledgement that must be ignored.
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0200;
      cycle();
      chk("tmo mem_req rise", 32'(bus.mem_req), 32'h1);
      repeat (TMO) cycle();
      chk("tmo no early valid", 32'(bus.d_valid), 32'h0);
      chk("tmo still busy",     32'(bus.mem_req), 32'h1);
      cycle();
      chk("tmo d_valid", 32'(bus.d_valid), 32'h1);
      chk("tmo d_err",   32'(bus.d_err),   32'h1);
      chk("tmo d_rdata", bus.d_rdata,      32'h0);
      bus.d_req = 1'b0;
      cycle();
      chk("tmo idle", 32'(bus.mem_req), 32'h0);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
      cycle();
      bus.mem_ready = 1'b0;
      cycle();
      chk("late ready d_valid",  32'(bus.d_valid),  32'h0);
      chk("late ready if_valid", 32'(bus.if_valid), 32'h0);
      chk("late ready busy",     32'(bus.busy),     32'h0);
      repeat (2) cycle();

      // Ready in the last counted cycle completes normally.
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0300;
      cycle();
      repeat (TMO) cycle();
      chk("edge no valid yet", 32'(bus.d_valid), 32'h0);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1234_5678;
      cycle();
      chk("edge d_valid", 32'(bus.d_valid), 32'h1);
      chk("edge d_err",   32'(bus.d_err),   32'h0);
      chk("edge d_rdata", bus.d_rdata,      32'h1234_5678);
      bus.d_req = 1'b0; bus.mem_ready = 1'b0;
      repeat (2) cycle();

      // Reset in the middle of a data access.
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_0400; bus.d_wdata = 32'hCAFE_F00D;
      cycle();
      chk("pre-reset busy", 32'(bus.busy), 32'h1);
      #2;
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk_all_zero("mid-reset");
      bus.d_req = 1'b0;
      model_reset();
      cycle();
      rst_n  = 1'b1;
      chk_en = 1'b1;
      repeat (4) cycle();
      chk("post-reset busy",    32'(bus.busy),    32'h0);
      chk("post-reset d_valid", 32'(bus.d_valid), 32'h0);

      // Random traffic; requesters hold until the model's completion pulse.
      if_pend = 0;
      d_pend  = 0;
      stall   = 0;
      for (int i = 0; i < 3000; i++) begin
         if (if_pend && e_if_valid) if_pend = 0;
         if (d_pend && e_d_valid) d_pend = 0;
         if (!if_pend && $urandom_range(0, 2) == 0) begin
            if_pend = 1;
            bus.if_addr = $urandom;
         end
         if (!d_pend && $urandom_range(0, 2) == 0) begin
            d_pend = 1;
            bus.d_addr  = $urandom;
            bus.d_we    = 1'($urandom_range(0, 1));
            bus.d_wdata = $urandom;
         end
         bus.if_req = if_pend;
         bus.d_req  = d_pend;
         if (stall > 0) begin
            stall--;
            bus.mem_ready = 1'b0;
         end else begin
            if ($urandom_range(0, 50) == 0) stall = 12;
            bus.mem_ready = ($urandom_range(0, 2) == 0);
         end
         bus.mem_rdata = $urandom;
         cycle();
      end

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
